ysyx_22040632_dcache: RTL and testbench
=======================================

# ysyx_22040632_dcache

Responder end of the `ysyx_22040632_mem2dc` MEM-stage data interface. It is a direct-mapped, write-through, no-write-allocate data cache, and it bridges misses and uncacheable accesses to a simple one-beat-per-request 64-bit memory bus. It sits between the MEM stage (`modport mem`) and the memory arbiter/AXI bridge.

## Interface
Parameters:
- `NSETS`, 16: number of lines; power of two. Index is `addr[4 +: $clog2(NSETS)]`; tag is the remaining upper address bits.
- `UC_BASE`, 32'h8000_0000: addresses below this are uncacheable (devices).

Ports:
- `clock` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `dc` modport `ysyx_22040632_mem2dc.dc`: `valid`, `req` (1 = write, 0 = read), `addr`, `size`, `data_write`, `wmask` (bit mask), `wmask_uncacheble` (byte strobe) in; `ready`, `data_read` out.
- `bus_valid` out 1: memory request valid.
- `bus_ready` in 1: memory request accepted.
- `bus_write` out 1: 1 = write beat.
- `bus_addr` out 32: beat address.
- `bus_size` out 3: copied from `dc.size` for uncacheable accesses; 3'd3 for refill beats.
- `bus_wdata` out 64: write data.
- `bus_wstrb` out 8: byte strobe.
- `bus_rvalid` in 1: response pulse; for reads, `bus_rdata` is valid in that cycle.
- `bus_rdata` in 64: response data.

## Operation
- Line: 16 bytes (two 64-bit words); `addr[3]` selects the word.
- Per line: valid bit, tag, and 128-bit data.
- MEM holds all `dc` inputs stable from `valid` until the `ready` pulse.
- `ready` is a single-cycle completion pulse.
- FSM states: IDLE, LOOKUP, REFILL0, REFILL1, WRITE, UNCACHED.
- IDLE: on `dc.valid`, latch the request and go to LOOKUP.
- LOOKUP:
  - Uncacheable: go to UNCACHED.
  - Cacheable read hit: `ready`=1, `data_read` = selected word; go to IDLE.
  - Cacheable read miss: go to REFILL0.
  - Cacheable write, hit or miss: on a hit, merge into the line as `(old & ~wmask) | (data_write & wmask)`; go to WRITE. A miss leaves the array untouched.
- REFILL0 / REFILL1:
  - Issue a read beat at line base +0 (REFILL0) and +8 (REFILL1), `bus_wstrb`=8'hFF.
  - Hold `bus_valid` until `bus_ready`, then wait for `bus_rvalid` and capture the beat.
  - After REFILL1's response, write tag, data and valid=1, then return to LOOKUP. The lookup now hits.
- WRITE: one bus write with `bus_addr`=`addr`, `bus_wdata`=`data_write`, `bus_wstrb`=`wmask_uncacheble`. On `bus_rvalid`: `ready`=1, go to IDLE.
- UNCACHED:
  - Single bus beat with `addr`, `size` and strobe unchanged.
  - On `bus_rvalid`: `ready`=1; for reads `data_read`=`bus_rdata` raw. Go to IDLE.
- `data_read` holds its last value between pulses. For writes it is don't-care and held unchanged.
- Byte extraction and sign extension are done by MEM, not by this block.

## Timing
- Reset values: all valid bits 0, state IDLE, `ready` 0, `data_read` 0, `bus_valid` 0, `bus_write` 0, `bus_addr`/`bus_wdata`/`bus_wstrb`/`bus_size` 0.
- Read hit: `valid` seen in cycle N, `ready` in N+1.
- Read miss: N+1 plus two bus round trips, then one LOOKUP cycle.
- Write and uncacheable accesses: one bus round trip; `ready` is asserted in the cycle `bus_rvalid` is seen.
- A new request is accepted in the cycle after the `ready` pulse at the earliest. `dc.valid` asserted in the same cycle as `ready` is treated as a new request only if still high in IDLE.
- Bus handshake:
  - `bus_*` request fields are stable while `bus_valid`=1 && !`bus_ready`.
  - `bus_valid` drops the cycle after acceptance.
  - `bus_rvalid` may arrive in the acceptance cycle or any later cycle, but never before acceptance.
- Reset mid-operation: return to IDLE and invalidate all lines. A late `bus_rvalid` is ignored, because IDLE ignores `bus_rvalid`.
- A write hit updates the array in LOOKUP, so a read issued after that write's `ready` observes the new data.
- Index/tag use the latched address, never live `dc.addr`.

## Structure
- Package `ysyx_22040632_dcache_pkg` holds:
  - the FSM state enum;
  - `LINE_BYTES`=16 and `WORD_SEL_BIT`=3;
  - a function computing `{tag, index}` widths from `NSETS`.
- Sub-module `ysyx_22040632_dcache_array` holds the valid/tag/data storage:
  - asynchronous read;
  - one synchronous write port with a full-line or single-word enable;
  - a synchronous clear of all valid bits on `reset`.

## Test plan
- Cold read 0x8000_0010; bus returns 0x1111 then 0x2222 -> two refill beats at 0x8000_0010 and 0x8000_0018, `ready` with `data_read`=0x1111. Repeat read of 0x8000_0018 -> `ready` one cycle after `valid`, data 0x2222, no bus traffic.
- Write hit 0x8000_0010, `data_write`=0xAABB, `wmask`=64'hFFFF, strobe 8'h03 -> one bus write with strobe 03; subsequent read returns 0x...AABB merged into 0x1111's upper bits, i.e. 0x0000_0000_0000_AABB.
- Write miss 0x8000_0100 -> bus write only; following read of 0x8000_0100 -> refill occurs (no allocation on write).
- Uncacheable read 0x1000_0000, size 2; bus returns 0xDEAD_BEEF -> single beat with `bus_size`=2, `data_read`=0xDEAD_BEEF, no array update.
- Reset asserted during REFILL1 -> next cycle all outputs are at reset values; a stray `bus_rvalid` is ignored; the earlier hit address now misses.
- `bus_ready` held low for 5 cycles -> `bus_*` request fields stay stable, and `ready` is not asserted until the response arrives.

Source files
------------

// File: rtl/ysyx_22040632_dcache_pkg.sv
// Shared types and geometry for the MEM-stage data cache.
// Includes the FSM encoding and the address split into tag, index and offset.
package ysyx_22040632_dcache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        REFILL0,
        REFILL1,
        WRITE,
        UNCACHED
    } state_t;

    localparam int ADDR_W       = 32;
    localparam int LINE_BYTES   = 16;
    localparam int WORD_SEL_BIT = 3;
    localparam int OFFSET_W     = $clog2(LINE_BYTES);

    typedef struct packed {
        logic [7:0] tag_w;
        logic [7:0] index_w;
    } addr_split_t;

    function automatic addr_split_t addr_split(input int nsets);
        addr_split_t s;
        s.index_w = 8'($clog2(nsets));
        s.tag_w   = 8'(ADDR_W - OFFSET_W - $clog2(nsets));
        return s;
    endfunction

    // Request fields captured in IDLE and held until completion.
    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [63:0] wdata;
        logic [63:0] wmask;
        logic [7:0]  wstrb;
    } dc_req_t;

endpackage

// File: rtl/ysyx_22040632_mem2dc.sv
// MEM-stage to data-cache request/response interface.
interface ysyx_22040632_mem2dc;
    logic        valid;
    logic        req;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [63:0] data_write;
    logic [63:0] wmask;
    logic [7:0]  wmask_uncacheble;
    logic        ready;
    logic [63:0] data_read;

    modport mem (
        output valid, req, addr, size, data_write, wmask, wmask_uncacheble,
        input  ready, data_read
    );

    modport dc (
        input  valid, req, addr, size, data_write, wmask, wmask_uncacheble,
        output ready, data_read
    );
endinterface

// File: rtl/ysyx_22040632_dcache_array.sv
// Valid/tag/data storage for the direct-mapped cache: asynchronous read,
// one synchronous write port (full line or single word).
module ysyx_22040632_dcache_array #(
    parameter int NSETS   = 16,
    parameter int INDEX_W = 4,
    parameter int TAG_W   = 24
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [INDEX_W-1:0] rd_index,
    output logic               rd_valid,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [127:0]       rd_line,
    input  logic               wr_en,
    input  logic               wr_full,
    input  logic               wr_word,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [127:0]       wr_line
);

    logic [NSETS-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [NSETS];
    logic [127:0]     data_q [NSETS];

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_line  = data_q[rd_index];

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
        end else if (wr_en && wr_full) begin
            valid_q[wr_index] <= 1'b1;
        end
    end

    // NOTE: tag/data are never reset; the valid bits alone make stale contents unreachable.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            if (wr_full) begin
                tag_q[wr_index]  <= wr_tag;
                data_q[wr_index] <= wr_line;
            end else if (wr_word) begin
                data_q[wr_index][127:64] <= wr_line[127:64];
            end else begin
                data_q[wr_index][63:0] <= wr_line[63:0];
            end
        end
    end

endmodule

// File: rtl/ysyx_22040632_dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache bridging the
// MEM stage to a one-beat-per-request 64-bit memory bus.
module ysyx_22040632_dcache
    import ysyx_22040632_dcache_pkg::*;
#(
    parameter int          NSETS   = 16,
    parameter logic [31:0] UC_BASE = 32'h8000_0000
) (
    input  logic                 clock,
    input  logic                 reset,
    ysyx_22040632_mem2dc.dc      dc,
    output logic                 bus_valid,
    input  logic                 bus_ready,
    output logic                 bus_write,
    output logic [31:0]          bus_addr,
    output logic [2:0]           bus_size,
    output logic [63:0]          bus_wdata,
    output logic [7:0]           bus_wstrb,
    input  logic                 bus_rvalid,
    input  logic [63:0]          bus_rdata
);

    localparam addr_split_t SPLIT   = addr_split(NSETS);
    localparam int          INDEX_W = int'(SPLIT.index_w);
    localparam int          TAG_W   = int'(SPLIT.tag_w);

    state_t        state_q, state_d;
    dc_req_t       req_q;
    logic [63:0]   beat0_q;
    logic          sent_q;
    logic [63:0]   data_read_q;

    logic               rd_valid;
    logic [TAG_W-1:0]   rd_tag;
    logic [127:0]       rd_line;
    logic               arr_we, arr_full;
    logic [127:0]       arr_wline;

    logic               load_rd;
    logic [63:0]        rd_word;
    logic               ready_o;

    // Index and tag always come from the latched request, never the live port.
    wire [INDEX_W-1:0] index     = req_q.addr[OFFSET_W +: INDEX_W];
    wire [TAG_W-1:0]   tag       = req_q.addr[ADDR_W-1 -: TAG_W];
    wire               word_sel  = req_q.addr[WORD_SEL_BIT];
    wire               cacheable = (req_q.addr >= UC_BASE);
    wire               hit       = rd_valid && (rd_tag == tag);
    wire [31:0]        line_base = {req_q.addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
    wire [63:0]        old_word  = word_sel ? rd_line[127:64] : rd_line[63:0];
    wire [63:0]        merged    = (old_word & ~req_q.wmask) | (req_q.wdata & req_q.wmask);
    // A response counts only once the beat has been accepted (now or earlier).
    wire               resp      = bus_rvalid && (sent_q || (bus_valid && bus_ready));

    ysyx_22040632_dcache_array #(
        .NSETS   (NSETS),
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W)
    ) u_array (
        .clock    (clock),
        .reset    (reset),
        .rd_index (index),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_line  (rd_line),
        .wr_en    (arr_we),
        .wr_full  (arr_full),
        .wr_word  (word_sel),
        .wr_index (index),
        .wr_tag   (tag),
        .wr_line  (arr_wline)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (dc.valid) state_d = LOOKUP;
            LOOKUP: begin
                if (!cacheable)        state_d = UNCACHED;
                else if (req_q.write)  state_d = WRITE;
                else if (hit)          state_d = IDLE;
                else                   state_d = REFILL0;
            end
            REFILL0:  if (resp) state_d = REFILL1;
            REFILL1:  if (resp) state_d = LOOKUP;
            WRITE:    if (resp) state_d = IDLE;
            UNCACHED: if (resp) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        bus_valid = 1'b0;
        bus_write = 1'b0;
        bus_addr  = '0;
        bus_size  = '0;
        bus_wdata = '0;
        bus_wstrb = '0;
        ready_o   = 1'b0;
        load_rd   = 1'b0;
        rd_word   = '0;
        arr_we    = 1'b0;
        arr_full  = 1'b0;
        arr_wline = '0;
        unique case (state_q)
            LOOKUP: begin
                if (cacheable && req_q.write) begin
                    arr_we    = hit;
                    arr_wline = {merged, merged};
                end else if (cacheable && hit) begin
                    ready_o = 1'b1;
                    load_rd = 1'b1;
                    rd_word = old_word;
                end
            end
            REFILL0, REFILL1: begin
                bus_valid = !sent_q;
                bus_addr  = (state_q == REFILL1) ? line_base + 32'(LINE_BYTES / 2) : line_base;
                bus_size  = 3'd3;
                bus_wstrb = 8'hFF;
                arr_we    = (state_q == REFILL1) && resp;
                arr_full  = 1'b1;
                arr_wline = {bus_rdata, beat0_q};
            end
            WRITE, UNCACHED: begin
                bus_valid = !sent_q;
                bus_write = (state_q == WRITE) || req_q.write;
                bus_addr  = req_q.addr;
                bus_size  = req_q.size;
                bus_wdata = req_q.wdata;
                bus_wstrb = req_q.wstrb;
                ready_o   = resp;
                load_rd   = resp && (state_q == UNCACHED) && !req_q.write;
                rd_word   = bus_rdata;
            end
            default: ;
        endcase
    end

    assign dc.ready     = ready_o;
    assign dc.data_read = load_rd ? rd_word : data_read_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            sent_q      <= 1'b0;
            req_q       <= '0;
            beat0_q     <= '0;
            data_read_q <= '0;
        end else begin
            if (resp) begin
                sent_q <= 1'b0;
            end else if (bus_valid && bus_ready) begin
                sent_q <= 1'b1;
            end
            if (state_q == IDLE && dc.valid) begin
                req_q <= {dc.req, dc.addr, dc.size, dc.data_write, dc.wmask, dc.wmask_uncacheble};
            end
            if (state_q == REFILL0 && resp) begin
                beat0_q <= bus_rdata;
            end
            if (load_rd) begin
                data_read_q <= rd_word;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22040632_dcache.sv
// Scoreboard bench for the data cache: a bus responder checks each expected
// beat, and a monitor checks each ready pulse against queued responses.
module tb_ysyx_22040632_dcache;

    logic        clock = 1'b0;
    logic        reset;
    logic        bus_valid, bus_ready, bus_write, bus_rvalid;
    logic [31:0] bus_addr;
    logic [2:0]  bus_size;
    logic [63:0] bus_wdata, bus_rdata;
    logic [7:0]  bus_wstrb;

    ysyx_22040632_mem2dc dc_if ();

    ysyx_22040632_dcache #(
        .NSETS   (16),
        .UC_BASE (32'h8000_0000)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .dc         (dc_if),
        .bus_valid  (bus_valid),
        .bus_ready  (bus_ready),
        .bus_write  (bus_write),
        .bus_addr   (bus_addr),
        .bus_size   (bus_size),
        .bus_wdata  (bus_wdata),
        .bus_wstrb  (bus_wstrb),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        chk;
        logic [63:0] data;
        logic [7:0]  id;
    } resp_t;

    typedef struct packed {
        logic        write;
        logic        chk_size;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [7:0]  wstrb;
        logic [63:0] wdata;
        logic [63:0] rdata;
        logic [3:0]  stall;
        logic        late;
    } beat_t;

    resp_t       exp_q[$];
    beat_t       bus_q[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    logic [7:0]  next_id = 8'd0;
    logic [63:0] last_rd = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_beat(input logic wr, input logic chk_size, input logic [31:0] a,
                             input logic [2:0] sz, input logic [7:0] st, input logic [63:0] wd,
                             input logic [63:0] rd, input logic [3:0] stall, input logic late);
        beat_t b;
        b = {wr, chk_size, a, sz, st, wd, rd, stall, late};
        bus_q.push_back(b);
    endtask

    task automatic push_resp(input logic chk, input logic [63:0] data);
        resp_t r;
        r = {chk, data, next_id};
        next_id++;
        exp_q.push_back(r);
    endtask

    task automatic drive(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                         input logic [63:0] wd, input logic [63:0] wm, input logic [7:0] st);
        dc_if.valid            = 1'b1;
        dc_if.req              = wr;
        dc_if.addr             = a;
        dc_if.size             = sz;
        dc_if.data_write       = wd;
        dc_if.wmask            = wm;
        dc_if.wmask_uncacheble = st;
    endtask

    // Issue one request and wait (bounded) for its ready pulse; lat counts
    // sampling points from the request cycle up to and including ready.
    task automatic issue(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                         input logic [63:0] wd, input logic [63:0] wm, input logic [7:0] st,
                         output int lat);
        drive(wr, a, sz, wd, wm, st);
        lat = 0;
        forever begin
            @(negedge clock);
            lat++;
            if (dc_if.ready) break;
            if (lat >= 200) begin
                check($sformatf("ready_timeout@%0h", a), {63'd0, dc_if.ready}, 64'd1);
                break;
            end
        end
        @(posedge clock); #1;
        dc_if.valid = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_bus_valid"}, {63'd0, bus_valid}, 64'd0);
        check({tag, "_bus_write"}, {63'd0, bus_write}, 64'd0);
        check({tag, "_bus_addr"},  {32'd0, bus_addr},  64'd0);
        check({tag, "_bus_size"},  {61'd0, bus_size},  64'd0);
        check({tag, "_bus_wdata"}, bus_wdata,          64'd0);
        check({tag, "_bus_wstrb"}, {56'd0, bus_wstrb}, 64'd0);
        check({tag, "_ready"},     {63'd0, dc_if.ready}, 64'd0);
        check({tag, "_data_read"}, dc_if.data_read,    64'd0);
    endtask

    // Response monitor.
    initial begin
        resp_t e;
        forever begin
            @(negedge clock);
            if (reset) begin
                last_rd = '0;
            end else if (dc_if.ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ready", {63'd0, dc_if.ready}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    if (e.chk) begin
                        check($sformatf("read_data#%0d", e.id), dc_if.data_read, e.data);
                        last_rd = e.data;
                    end else begin
                        check($sformatf("write_hold#%0d", e.id), dc_if.data_read, last_rd);
                    end
                end
            end
        end
    end

    // Bus responder.
    initial begin
        beat_t b;
        logic  aborted;
        bus_ready  = 1'b0;
        bus_rvalid = 1'b0;
        bus_rdata  = '0;
        forever begin
            @(posedge clock); #2;
            if (!reset && bus_valid) begin
                if (bus_q.size() == 0) begin
                    check($sformatf("unexpected_beat@%0h", bus_addr), {63'd0, bus_valid}, 64'd0);
                    b = '0;
                end else begin
                    b = bus_q.pop_front();
                    check($sformatf("beat_addr@%0h", b.addr), {32'd0, bus_addr}, {32'd0, b.addr});
                    check($sformatf("beat_write@%0h", b.addr), {63'd0, bus_write}, {63'd0, b.write});
                    check($sformatf("beat_wstrb@%0h", b.addr), {56'd0, bus_wstrb}, {56'd0, b.wstrb});
                    if (b.chk_size) check($sformatf("beat_size@%0h", b.addr), {61'd0, bus_size}, {61'd0, b.size});
                    if (b.write)    check($sformatf("beat_wdata@%0h", b.addr), bus_wdata, b.wdata);
                end
                aborted = 1'b0;
                for (int i = 0; i < int'(b.stall); i++) begin
                    @(posedge clock); #2;
                    if (reset) begin
                        aborted = 1'b1;
                        break;
                    end
                    check("stall_valid", {63'd0, bus_valid}, 64'd1);
                    check("stall_addr", {32'd0, bus_addr}, {32'd0, b.addr});
                    check("stall_write_wstrb", {55'd0, bus_write, bus_wstrb}, {55'd0, b.write, b.wstrb});
                    if (b.chk_size) check("stall_size", {61'd0, bus_size}, {61'd0, b.size});
                    if (b.write)    check("stall_wdata", bus_wdata, b.wdata);
                    check("stall_no_ready", {63'd0, dc_if.ready}, 64'd0);
                end
                if (aborted) begin
                    while (reset) begin
                        @(posedge clock); #2;
                    end
                    // Late response to the cancelled beat; the cache must ignore it.
                    bus_rvalid = 1'b1;
                    bus_rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
                    @(posedge clock); #2;
                    bus_rvalid = 1'b0;
                    continue;
                end
                bus_ready = 1'b1;
                if (!b.late) begin
                    bus_rvalid = 1'b1;
                    bus_rdata  = b.rdata;
                end
                @(posedge clock); #2;
                bus_ready = 1'b0;
                if (b.late) begin
                    check("valid_drops_after_accept", {63'd0, bus_valid}, 64'd0);
                    bus_rvalid = 1'b1;
                    bus_rdata  = b.rdata;
                    @(posedge clock); #2;
                end
                bus_rvalid = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int lat;
        int w;
        reset = 1'b1;
        dc_if.valid = 1'b0;
        drive(1'b0, 32'h0, 3'd0, 64'h0, 64'h0, 8'h0);
        dc_if.valid = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_reset_outputs("por");
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;

        // Cold read: two refill beats, second one stalled and answered late.
        push_beat(1'b0, 1'b1, 32'h8000_0010, 3'd3, 8'hFF, 64'h0, 64'h1111, 4'd0, 1'b0);
        push_beat(1'b0, 1'b1, 32'h8000_0018, 3'd3, 8'hFF, 64'h0, 64'h2222, 4'd1, 1'b1);
        push_resp(1'b1, 64'h1111);
        issue(1'b0, 32'h8000_0010, 3'd3, 64'h0, 64'h0, 8'hFF, lat);

        push_resp(1'b1, 64'h2222);
        issue(1'b0, 32'h8000_0018, 3'd3, 64'h0, 64'h0, 8'hFF, lat);
        check("hit_latency_0018", 64'(lat), 64'd2);

        // Write hit: merged into word 0 of the line, plus one bus write.
        push_beat(1'b1, 1'b0, 32'h8000_0010, 3'd1, 8'h03, 64'hAABB, 64'h0, 4'd0, 1'b1);
        push_resp(1'b0, 64'h0);
        issue(1'b1, 32'h8000_0010, 3'd1, 64'hAABB, 64'hFFFF, 8'h03, lat);

        push_resp(1'b1, 64'h0000_0000_0000_AABB);
        issue(1'b0, 32'h8000_0010, 3'd3, 64'h0, 64'h0, 8'hFF, lat);
        check("hit_latency_after_write", 64'(lat), 64'd2);

        push_resp(1'b1, 64'h2222);
        issue(1'b0, 32'h8000_0018, 3'd3, 64'h0, 64'h0, 8'hFF, lat);

        // Write miss goes to the bus only; the next read must refill.
        push_beat(1'b1, 1'b0, 32'h8000_0100, 3'd2, 8'h0F, 64'h5A5A, 64'h0, 4'd0, 1'b0);
        push_resp(1'b0, 64'h0);
        issue(1'b1, 32'h8000_0100, 3'd2, 64'h5A5A, 64'hFFFF_FFFF, 8'h0F, lat);

        push_beat(1'b0, 1'b1, 32'h8000_0100, 3'd3, 8'hFF, 64'h0, 64'h3333, 4'd0, 1'b1);
        push_beat(1'b0, 1'b1, 32'h8000_0108, 3'd3, 8'hFF, 64'h0, 64'h4444, 4'd0, 1'b0);
        push_resp(1'b1, 64'h3333);
        issue(1'b0, 32'h8000_0100, 3'd3, 64'h0, 64'h0, 8'hFF, lat);

        push_resp(1'b1, 64'h4444);
        issue(1'b0, 32'h8000_0108, 3'd3, 64'h0, 64'h0, 8'hFF, lat);
        check("hit_latency_0108", 64'(lat), 64'd2);

        // Uncacheable reads: bus_ready held low for five cycles, then no caching.
        push_beat(1'b0, 1'b1, 32'h1000_0000, 3'd2, 8'h0F, 64'h0, 64'hDEAD_BEEF, 4'd5, 1'b1);
        push_resp(1'b1, 64'hDEAD_BEEF);
        issue(1'b0, 32'h1000_0000, 3'd2, 64'h0, 64'h0, 8'h0F, lat);

        push_beat(1'b0, 1'b1, 32'h1000_0000, 3'd2, 8'h0F, 64'h0, 64'hCAFE_F00D, 4'd0, 1'b0);
        push_resp(1'b1, 64'hCAFE_F00D);
        issue(1'b0, 32'h1000_0000, 3'd2, 64'h0, 64'h0, 8'h0F, lat);

        push_beat(1'b1, 1'b1, 32'h1000_0008, 3'd3, 8'hF0, 64'h0123_4567_89AB_CDEF, 64'h0, 4'd2, 1'b0);
        push_resp(1'b0, 64'h0);
        issue(1'b1, 32'h1000_0008, 3'd3, 64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_0000_0000, 8'hF0, lat);

        // Reset while REFILL1 waits on bus_ready.
        push_beat(1'b0, 1'b1, 32'h8000_0200, 3'd3, 8'hFF, 64'h0, 64'h5555, 4'd0, 1'b0);
        push_beat(1'b0, 1'b1, 32'h8000_0208, 3'd3, 8'hFF, 64'h0, 64'h6666, 4'd8, 1'b0);
        drive(1'b0, 32'h8000_0200, 3'd3, 64'h0, 64'h0, 8'hFF);
        w = 0;
        while (!(bus_valid && bus_addr == 32'h8000_0208) && w < 100) begin
            @(negedge clock);
            w++;
        end
        if (w >= 100) check("refill1_timeout", {63'd0, bus_valid}, 64'd1);
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b1;
        dc_if.valid = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check_reset_outputs("mid_reset");
        repeat (3) @(posedge clock);
        #1;

        // The line cached before the reset must miss again.
        push_beat(1'b0, 1'b1, 32'h8000_0010, 3'd3, 8'hFF, 64'h0, 64'h7777, 4'd0, 1'b0);
        push_beat(1'b0, 1'b1, 32'h8000_0018, 3'd3, 8'hFF, 64'h0, 64'h8888, 4'd0, 1'b1);
        push_resp(1'b1, 64'h7777);
        issue(1'b0, 32'h8000_0010, 3'd3, 64'h0, 64'h0, 8'hFF, lat);

        push_resp(1'b1, 64'h8888);
        issue(1'b0, 32'h8000_0018, 3'd3, 64'h0, 64'h0, 8'hFF, lat);

        repeat (5) @(posedge clock);
        @(negedge clock);
        check("bus_beats_left", 64'(bus_q.size()), 64'd0);
        check("responses_left", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
